// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine front-panel controller.
package vend_pkg;
    localparam int CV_W     = 10;
    localparam int COIN_MAX = 1023;

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_HELLO  = 2'd1,
        S_INSERT = 2'd2
    } state_t;

    localparam logic [CV_W-1:0] COIN_U0 = 10'd1;
    localparam logic [CV_W-1:0] COIN_U1 = 10'd2;
    localparam logic [CV_W-1:0] COIN_U2 = 10'd10;
    localparam logic [CV_W-1:0] COIN_U3 = 10'd20;

    // Lowest set coin bit wins; simultaneous higher coins are dropped.
    function automatic logic [CV_W-1:0] coin_unit(input logic [3:0] ev);
        if (ev[0])      return COIN_U0;
        else if (ev[1]) return COIN_U1;
        else if (ev[2]) return COIN_U2;
        else if (ev[3]) return COIN_U3;
        else            return '0;
    endfunction
endpackage

// File: rtl/coin_ctrl_if.sv
// Front-panel bundle: raw switch/button inputs and the display/dispense outputs.
interface coin_ctrl_if;
    import vend_pkg::*;

    logic            power_sw;
    logic            start_btn;
    logic [3:0]      coin_btn;
    logic [1:0]      buy_btn;
    logic            cancel_btn;
    logic            light;
    logic            op_start;
    logic [CV_W-1:0] coin_val;
    logic [CV_W-1:0] change_val;
    logic [1:0]      vend;
    logic            err;

    modport master (
        output power_sw, start_btn, coin_btn, buy_btn, cancel_btn,
        input  light, op_start, coin_val, change_val, vend, err
    );
    modport slave (
        input  power_sw, start_btn, coin_btn, buy_btn, cancel_btn,
        output light, op_start, coin_val, change_val, vend, err
    );
endinterface

// File: rtl/btn_debounce.sv
// One raw input: 2-flop synchroniser, stable-sample counter, debounced level and rise pulse.
module btn_debounce #(
    parameter int DEB_CNT = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int CW = $clog2(DEB_CNT + 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            rise <= 1'b0;
            // Any sample matching the current level restarts the count.
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CNT - 1)) begin
                cnt   <= '0;
                level <= s2;
                rise  <= s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/coin_ctrl.sv
// Debounces the front panel, accumulates credit and runs the purchase/refund FSM.
module coin_ctrl
    import vend_pkg::*;
#(
    parameter int              DEB_CNT = 1_000_000,
    parameter logic [CV_W-1:0] PRICE0  = 10'd5,
    parameter logic [CV_W-1:0] PRICE1  = 10'd10
) (
    input  logic  clk,
    input  logic  rst_n,
    coin_ctrl_if.slave bus
);
    localparam int NB = 9;

    // Bit map: 0 power, 1 start, 5:2 coin, 7:6 buy, 8 cancel.
    logic [NB-1:0] raw, lvl, rise;
    assign raw = {bus.cancel_btn, bus.buy_btn, bus.coin_btn, bus.start_btn, bus.power_sw};

    for (genvar i = 0; i < NB; i++) begin : g_deb
        btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw[i]),
            .level (lvl[i]),
            .rise  (rise[i])
        );
    end

    logic       power, ev_start, ev_cancel;
    logic [3:0] ev_coin;
    logic [1:0] ev_buy;
    logic       unused_deb;
    assign power      = lvl[0];
    assign ev_start   = rise[1];
    assign ev_coin    = rise[5:2];
    assign ev_buy     = rise[7:6];
    assign ev_cancel  = rise[8];
    assign unused_deb = &{1'b0, lvl[NB-1:1], rise[0]};

    state_t          state;
    logic            light, op_start, err;
    logic [CV_W-1:0] credit, change;
    logic [1:0]      vend;

    logic [CV_W:0]   coin_sum;
    logic            buy_k;
    logic [CV_W-1:0] price;
    assign coin_sum = {1'b0, credit} + {1'b0, coin_unit(ev_coin)};
    assign buy_k    = ~ev_buy[0];
    assign price    = buy_k ? PRICE1 : PRICE0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_OFF;
            light    <= 1'b0;
            op_start <= 1'b0;
            credit   <= '0;
            change   <= '0;
            vend     <= '0;
            err      <= 1'b0;
        end else begin
            vend <= '0;
            err  <= 1'b0;
            if (!power) begin
                state    <= S_OFF;
                light    <= 1'b0;
                op_start <= 1'b0;
                credit   <= '0;
            end else begin
                case (state)
                    S_OFF: begin
                        state <= S_HELLO;
                        light <= 1'b1;
                    end
                    S_HELLO: if (ev_start) begin
                        state    <= S_INSERT;
                        op_start <= 1'b1;
                    end
                    S_INSERT: begin
                        if (ev_cancel) begin
                            change   <= credit;
                            credit   <= '0;
                            state    <= S_HELLO;
                            op_start <= 1'b0;
                        end else if (|ev_buy) begin
                            if (credit >= price) begin
                                credit <= credit - price;
                                vend   <= buy_k ? 2'b10 : 2'b01;
                            end else begin
                                err <= 1'b1;
                            end
                        end else if (|ev_coin) begin
                            if (coin_sum > (CV_W+1)'(COIN_MAX)) err <= 1'b1;
                            else                                credit <= coin_sum[CV_W-1:0];
                        end
                    end
                    default: begin
                        state    <= S_OFF;
                        light    <= 1'b0;
                        op_start <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.light      = light;
    assign bus.op_start   = op_start;
    assign bus.coin_val   = credit;
    assign bus.change_val = change;
    assign bus.vend       = vend;
    assign bus.err        = err;
endmodule

// File: tb/tb_coin_ctrl.sv
// Randomised bench for coin_ctrl against an event-level model of the panel rules.
module tb_coin_ctrl;
    localparam int DEB  = 4;
    localparam int HOLD = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    coin_ctrl_if bus();
    coin_ctrl #(.DEB_CNT(DEB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    // Observed pulse totals.
    int tot_v0 = 0, tot_v1 = 0, tot_err = 0;
    always @(negedge clk) begin
        if (bus.vend[0]) tot_v0  <= tot_v0 + 1;
        if (bus.vend[1]) tot_v1  <= tot_v1 + 1;
        if (bus.err)     tot_err <= tot_err + 1;
    end

    // Model: mode 0 off, 1 hello, 2 insert; credit/change in half-yuan.
    int m_st = 0, m_cr = 0, m_ch = 0;
    int e_v0 = 0, e_v1 = 0, e_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".coin_val"},   int'(bus.coin_val),   m_cr);
        chk({tag, ".change_val"}, int'(bus.change_val), m_ch);
        chk({tag, ".light"},      int'(bus.light),      (m_st != 0) ? 1 : 0);
        chk({tag, ".op_start"},   int'(bus.op_start),   (m_st == 2) ? 1 : 0);
        chk({tag, ".vend0"},      tot_v0,  e_v0);
        chk({tag, ".vend1"},      tot_v1,  e_v1);
        chk({tag, ".err"},        tot_err, e_err);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model(input logic st, input logic [3:0] c, input logic [1:0] b, input logic cn);
        int unit, price;
        if (m_st == 2) begin
            if (cn) begin
                m_ch = m_cr; m_cr = 0; m_st = 1;
            end else if (b != 2'b00) begin
                price = b[0] ? 5 : 10;
                if (m_cr >= price) begin
                    m_cr -= price;
                    if (b[0]) e_v0++; else e_v1++;
                end else e_err++;
            end else if (c != 4'b0000) begin
                unit = c[0] ? 1 : c[1] ? 2 : c[2] ? 10 : 20;
                if (m_cr + unit > 1023) e_err++; else m_cr += unit;
            end
        end else if (m_st == 1 && st) begin
            m_st = 2;
        end
    endtask

    task automatic press(input logic st, input logic [3:0] c, input logic [1:0] b, input logic cn);
        @(negedge clk);
        bus.start_btn = st; bus.coin_btn = c; bus.buy_btn = b; bus.cancel_btn = cn;
        cyc(HOLD);
        bus.start_btn = 1'b0; bus.coin_btn = 4'b0; bus.buy_btn = 2'b0; bus.cancel_btn = 1'b0;
        cyc(HOLD);
        model(st, c, b, cn);
    endtask

    task automatic set_power(input logic v);
        @(negedge clk);
        bus.power_sw = v;
        cyc(HOLD);
        if (!v) begin m_st = 0; m_cr = 0; end
        else if (m_st == 0) m_st = 1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        cyc(2);
        chk({tag, ".rst_light"},  int'(bus.light),      0);
        chk({tag, ".rst_op"},     int'(bus.op_start),   0);
        chk({tag, ".rst_coin"},   int'(bus.coin_val),   0);
        chk({tag, ".rst_change"}, int'(bus.change_val), 0);
        chk({tag, ".rst_vend"},   int'(bus.vend),       0);
        chk({tag, ".rst_err"},    int'(bus.err),        0);
        m_st = 0; m_cr = 0; m_ch = 0;
        rst_n = 1'b1;
        cyc(HOLD);
        if (bus.power_sw) m_st = 1;
    endtask

    initial begin
        int n;
        int r;
        bus.power_sw = 1'b0; bus.start_btn = 1'b0; bus.coin_btn = 4'b0;
        bus.buy_btn = 2'b0; bus.cancel_btn = 1'b0;
        cyc(3);
        chk("reset.light",  int'(bus.light),      0);
        chk("reset.op",     int'(bus.op_start),   0);
        chk("reset.coin",   int'(bus.coin_val),   0);
        chk("reset.change", int'(bus.change_val), 0);
        chk("reset.vend",   int'(bus.vend),       0);
        chk("reset.err",    int'(bus.err),        0);
        rst_n = 1'b1;
        cyc(HOLD);
        check_all("idle");
        press(1'b1, 4'b0, 2'b0, 1'b0);
        check_all("start_while_off");
        set_power(1'b1);
        check_all("power_on");

        // Start press: raw edge to op_start is sync + debounce + FSM register.
        @(negedge clk);
        bus.start_btn = 1'b1;
        n = 0;
        while (!bus.op_start && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("start_latency", n, DEB + 3);
        cyc(HOLD);
        bus.start_btn = 1'b0;
        cyc(HOLD);
        model(1'b1, 4'b0, 2'b0, 1'b0);
        check_all("insert");

        press(1'b0, 4'b1000, 2'b0, 1'b0);
        press(1'b0, 4'b0100, 2'b0, 1'b0);
        press(1'b0, 4'b0001, 2'b0, 1'b0);
        check_all("coins31");
        chk("coins31.value", int'(bus.coin_val), 31);
        press(1'b0, 4'b0, 2'b10, 1'b0);
        check_all("buy1");
        press(1'b0, 4'b0, 2'b01, 1'b0);
        press(1'b0, 4'b0, 2'b01, 1'b0);
        check_all("buy0x2");
        chk("buy0x2.value", int'(bus.coin_val), 11);
        press(1'b0, 4'b0, 2'b10, 1'b0);
        press(1'b0, 4'b0010, 2'b0, 1'b0);
        press(1'b0, 4'b0, 2'b01, 1'b0);
        check_all("buy_short");
        press(1'b0, 4'b0, 2'b0, 1'b1);
        check_all("cancel3");
        chk("cancel3.change", int'(bus.change_val), 3);

        press(1'b1, 4'b0, 2'b0, 1'b0);
        for (int i = 0; i < 50; i++) press(1'b0, 4'b1000, 2'b0, 1'b0);
        press(1'b0, 4'b0100, 2'b0, 1'b0);
        check_all("credit1010");
        press(1'b0, 4'b1000, 2'b0, 1'b0);
        check_all("overflow_reject");
        press(1'b0, 4'b0001, 2'b0, 1'b0);
        check_all("credit1011");
        press(1'b0, 4'b1100, 2'b0, 1'b0);
        check_all("multi_coin");
        press(1'b0, 4'b0, 2'b11, 1'b0);
        check_all("both_buy");

        // Short bounce on coin[1] before it settles: must count once.
        @(negedge clk); bus.coin_btn = 4'b0010;
        @(negedge clk); bus.coin_btn = 4'b0000;
        @(negedge clk); bus.coin_btn = 4'b0010;
        cyc(HOLD);
        bus.coin_btn = 4'b0000;
        cyc(HOLD);
        model(1'b0, 4'b0010, 2'b0, 1'b0);
        check_all("bounce");

        press(1'b0, 4'b0, 2'b01, 1'b1);
        check_all("cancel_and_buy");
        press(1'b1, 4'b0, 2'b0, 1'b0);
        press(1'b0, 4'b1000, 2'b0, 1'b0);
        check_all("credit20");
        set_power(1'b0);
        check_all("power_off");
        set_power(1'b1);
        check_all("power_back");
        press(1'b1, 4'b0, 2'b0, 1'b0);
        press(1'b0, 4'b0100, 2'b0, 1'b0);
        do_reset("mid_txn");
        check_all("after_reset");

        for (int i = 0; i < 120; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                set_power(1'b0); check_all("rnd_off");
                set_power(1'b1);
            end else if (r < 5) begin
                do_reset("rnd");
            end else if (r < 15) begin
                press(1'b1, 4'b0, 2'b0, 1'b0);
            end else if (r < 60) begin
                press(1'b0, 4'($urandom_range(1, 15)), 2'b0, 1'b0);
            end else if (r < 82) begin
                press(1'b0, 4'b0, 2'($urandom_range(1, 3)), 1'b0);
            end else if (r < 92) begin
                press(1'b0, 4'b0, 2'b0, 1'b1);
            end else begin
                press(1'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'b1);
            end
            check_all("rnd");
        end

        do_reset("final");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
